// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory: widths, the default program
// image and the byte-address to word-index decode.
package instr_mem_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int IMAGE_WORDS = 64;
  localparam int IDX_W       = $clog2(IMAGE_WORDS);

  localparam logic [DATA_W-1:0] NOP_WORD = 16'h0000;

  typedef logic [DATA_W-1:0] image_t [IMAGE_WORDS];

  // Word n lives at byte address 2*n; everything past 0x34 is NOP.
  localparam image_t DEFAULT_IMAGE = '{
    0:  16'h2101, 1:  16'h2202, 2:  16'h0312, 3:  16'h4301,
    4:  16'h5203, 5:  16'h6104, 6:  16'h7005, 7:  16'h8106,
    8:  16'h0123, 9:  16'h1234, 10: 16'h2345, 11: 16'h3456,
    12: 16'h4567, 13: 16'h9A10, 14: 16'h5678, 15: 16'h6789,
    16: 16'h789A, 17: 16'h89AB, 18: 16'h9ABC, 19: 16'hABCD,
    20: 16'hBCDE, 21: 16'hCDEF, 22: 16'hDEF0, 23: 16'hE014,
    24: 16'hF00C, 25: 16'h0F0F, 26: 16'hFFFF,
    default: NOP_WORD
  };

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             in_range;
  } word_sel_t;

  // Bit 0 is dropped; the range test uses the full word index so that
  // addresses beyond the array never alias back onto low words.
  function automatic word_sel_t byte_to_word(input logic [ADDR_W-1:0] byte_addr,
                                             input int unsigned depth);
    word_sel_t sel;
    sel.index    = byte_addr[IDX_W:1];
    sel.in_range = (32'(byte_addr[ADDR_W-1:1]) < depth);
    return sel;
  endfunction

endpackage

// File: rtl/instruction_mem.sv
// Program memory for the 16-bit CPU: registered read, synchronous write port,
// synchronous reset that reloads the default program image.
module instruction_mem #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [DATA_W-1:0] wr_data
);
  import instr_mem_pkg::*;

  // Power-up contents match the post-reset contents.
  logic [DATA_W-1:0] mem [DEPTH_WORDS] = DEFAULT_IMAGE;
  logic [DATA_W-1:0] instr_q = NOP_WORD;

  word_sel_t rd_sel;
  word_sel_t wr_sel;

  assign rd_sel = byte_to_word(address, DEPTH_WORDS);
  assign wr_sel = byte_to_word(wr_address, DEPTH_WORDS);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= DEFAULT_IMAGE;
    end else if (wr_en && wr_sel.in_range) begin
      mem[wr_sel.index] <= wr_data;
    end
  end

  // Reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_WORD;
    end else if (rd_sel.in_range) begin
      instr_q <= mem[rd_sel.index];
    end else begin
      instr_q <= NOP_WORD;
    end
  end

  assign instruction = instr_q;

endmodule

// File: tb/tb_instruction_mem.sv
// Self-checking bench for instruction_mem: directed scenarios plus randomized
// reads/writes compared against a word-array model of the memory.
module tb_instruction_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [15:0] instruction;
  logic        wr_en = 1'b0;
  logic [15:0] wr_address = 16'h0000;
  logic [15:0] wr_data = 16'h0000;

  int checks = 0;
  int failures = 0;

  logic [15:0] golden [64];
  logic [15:0] model  [64];

  instruction_mem dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .instruction(instruction),
    .wr_en(wr_en),
    .wr_address(wr_address),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic load_golden();
    logic [15:0] img [27];
    img = '{16'h2101, 16'h2202, 16'h0312, 16'h4301, 16'h5203, 16'h6104, 16'h7005, 16'h8106,
            16'h0123, 16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h9A10, 16'h5678, 16'h6789,
            16'h789A, 16'h89AB, 16'h9ABC, 16'hABCD, 16'hBCDE, 16'hCDEF, 16'hDEF0, 16'hE014,
            16'hF00C, 16'h0F0F, 16'hFFFF};
    for (int i = 0; i < 64; i++) golden[i] = (i < 27) ? img[i] : 16'h0000;
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    int unsigned w;
    w = int'(a) / 2;
    return (w < 64) ? model[w] : 16'h0000;
  endfunction

  // Drives one clock cycle and returns what the memory should present after it.
  task automatic drive_cycle(input logic rst, input logic [15:0] addr, input logic we,
                             input logic [15:0] waddr, input logic [15:0] wdata,
                             output logic [15:0] expected);
    reset = rst; address = addr; wr_en = we; wr_address = waddr; wr_data = wdata;
    @(posedge clk);
    if (rst) begin
      expected = 16'h0000;
      for (int i = 0; i < 64; i++) model[i] = golden[i];
    end else begin
      expected = model_read(addr);
      if (we && (int'(waddr) / 2) < 64) model[int'(waddr) / 2] = wdata;
    end
    #1;
    reset = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_power_up();
    logic [15:0] exp;
    checks++;
    if (instruction !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL power_up_output: got %h expected 0000", instruction);
    end
    drive_cycle(1'b0, 16'h0002, 1'b0, 16'h0000, 16'h0000, exp);
    checks++;
    if (instruction !== exp || exp !== 16'h2202) begin
      failures++;
      $display("[TB] FAIL power_up_image: got %h expected %h", instruction, exp);
    end
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    drive_cycle(1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, exp);
    checks++;
    if (instruction !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_output: got %h expected 0000", instruction);
    end
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, exp);
    checks++;
    if (instruction !== exp || exp !== 16'h2101) begin
      failures++;
      $display("[TB] FAIL first_read: got %h expected %h", instruction, exp);
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] exp;
    logic [15:0] addrs [4];
    addrs = '{16'hFFFF, 16'h0080, 16'h8000, 16'h0081};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, addrs[i], 1'b0, 16'h0000, 16'h0000, exp);
      checks++;
      if (instruction !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL oob_read_%h: got %h expected 0000", addrs[i], instruction);
      end
    end
  endtask

  task automatic test_sequence();
    logic [15:0] exp;
    logic [15:0] addrs [5];
    logic [15:0] want  [5];
    addrs = '{16'h001A, 16'h002E, 16'h0030, 16'h0034, 16'h0035};
    want  = '{16'h9A10, 16'hE014, 16'hF00C, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, addrs[i], 1'b0, 16'h0000, 16'h0000, exp);
      checks++;
      if (instruction !== want[i] || exp !== want[i]) begin
        failures++;
        $display("[TB] FAIL seq_read_%h: got %h expected %h", addrs[i], instruction, want[i]);
      end
    end
  endtask

  task automatic test_read_during_write();
    logic [15:0] exp;
    drive_cycle(1'b0, 16'h001A, 1'b1, 16'h001A, 16'hBEEF, exp);
    checks++;
    if (instruction !== 16'h9A10) begin
      failures++;
      $display("[TB] FAIL rdw_old: got %h expected 9A10", instruction);
    end
    drive_cycle(1'b0, 16'h001B, 1'b0, 16'h0000, 16'h0000, exp);
    checks++;
    if (instruction !== 16'hBEEF) begin
      failures++;
      $display("[TB] FAIL rdw_new: got %h expected BEEF", instruction);
    end
  endtask

  task automatic test_oob_write();
    logic [15:0] exp;
    drive_cycle(1'b0, 16'h0000, 1'b1, 16'h0100, 16'h5A5A, exp);
    drive_cycle(1'b0, 16'h0100, 1'b0, 16'h0000, 16'h0000, exp);
    checks++;
    if (instruction !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL oob_write_read: got %h expected 0000", instruction);
    end
    // 0x0100 would alias word 0 if the index were truncated.
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, exp);
    checks++;
    if (instruction !== 16'h2101) begin
      failures++;
      $display("[TB] FAIL oob_write_alias: got %h expected 2101", instruction);
    end
  endtask

  task automatic test_reset_priority();
    logic [15:0] exp;
    drive_cycle(1'b0, 16'h0000, 1'b1, 16'h0030, 16'h1111, exp);
    drive_cycle(1'b0, 16'h0030, 1'b0, 16'h0000, 16'h0000, exp);
    checks++;
    if (instruction !== 16'h1111) begin
      failures++;
      $display("[TB] FAIL overwrite_0030: got %h expected 1111", instruction);
    end
    drive_cycle(1'b1, 16'h0030, 1'b1, 16'h0030, 16'h2222, exp);
    checks++;
    if (instruction !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_with_write_out: got %h expected 0000", instruction);
    end
    drive_cycle(1'b0, 16'h0030, 1'b0, 16'h0000, 16'h0000, exp);
    checks++;
    if (instruction !== 16'hF00C) begin
      failures++;
      $display("[TB] FAIL reset_restores_0030: got %h expected F00C", instruction);
    end
    drive_cycle(1'b0, 16'h001A, 1'b0, 16'h0000, 16'h0000, exp);
    checks++;
    if (instruction !== 16'h9A10) begin
      failures++;
      $display("[TB] FAIL reset_restores_001A: got %h expected 9A10", instruction);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    logic [15:0] a;
    logic [15:0] wa;
    logic        we;
    for (int i = 0; i < 300; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h7F));
      we = ($urandom_range(0, 2) == 0);
      wa = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h7F));
      drive_cycle(1'b0, a, we, wa, 16'($urandom), exp);
      checks++;
      if (instruction !== exp) begin
        failures++;
        $display("[TB] FAIL random_read_%0d addr %h: got %h expected %h", i, a, instruction, exp);
      end
    end
  endtask

  initial begin
    load_golden();
    for (int i = 0; i < 64; i++) model[i] = golden[i];
    #1;
    test_power_up();
    test_reset();
    test_out_of_range();
    test_sequence();
    test_read_during_write();
    test_oob_write();
    test_reset_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
